// File: rtl/if_pc_stage_if.sv
// rtl/if_pc_stage_if.sv - instruction-memory bus between the fetch stage and imem
interface if_pc_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_pc_stage.sv
// rtl/if_pc_stage.sv - RV32I fetch stage: PC register, stall/redirect, IF/ID flush, perf counters
module if_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_use_stall_flag,
  input  logic               jump_en,
  input  logic [31:0]        jump_target,
  if_pc_stage_if.master      imem,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc4_o,
  output logic [31:0]        inst_o,
  output logic               jump_stall_flag,
  output logic               misalign_err,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  logic [31:0] r_pc;
  logic        r_misalign;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] w_pc4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_pc4 = r_pc + 32'd4;

  // Stall outranks redirect, so a jump seen during a stall never flushes IF/ID.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (load_use_stall_flag) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end else if (jump_en) begin
      r_pc        <= {jump_target[31:2], 2'b00};
      r_flush_cnt <= sat_inc(r_flush_cnt);
      if (jump_target[1:0] != 2'b00) r_misalign <= 1'b1;
    end else begin
      r_pc        <= w_pc4;
      r_fetch_cnt <= sat_inc(r_fetch_cnt);
    end
  end

  assign imem.imem_addr      = r_pc;
  assign pc_o                = r_pc;
  assign pc4_o               = w_pc4;
  assign inst_o              = imem.imem_rdata;
  assign jump_stall_flag     = jump_en & ~load_use_stall_flag & rst;
  assign misalign_err        = r_misalign;
  assign fetch_cnt           = r_fetch_cnt;
  assign stall_cnt           = r_stall_cnt;
  assign flush_cnt           = r_flush_cnt;

endmodule

// File: doc/if_pc_stage.md
# if_pc_stage

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter, drives the instruction-memory address, and presents `pc`, `pc+4` and the fetched instruction to IF/ID. It also applies load-use stalls and EX-stage jump/branch redirects, generates the IF/ID flush, and keeps saturating fetch, stall and flush performance counters.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `load_use_stall_flag`  in  1  hazard unit: hold PC this cycle.
- `jump_en`  in  1  EX stage: taken branch, JAL or JALR resolved this cycle.
- `jump_target`  in  32  redirect address, valid when `jump_en`=1.
- `imem_addr`  out  32  instruction-memory address; combinational read.
- `imem_rdata`  in  32  instruction word at `imem_addr`, same cycle.
- `pc_o`  out  32  current PC, to IF/ID `pc_i`.
- `pc4_o`  out  32  `pc_o`+4, to IF/ID `pc4_i`.
- `inst_o`  out  32  `imem_rdata` passed through, to IF/ID `inst_i`.
- `jump_stall_flag`  out  1  IF/ID flush request.
- `misalign_err`  out  1  sticky flag: a redirect target had `[1:0]`≠0.
- `fetch_cnt`  out  32  count of fetches accepted into IF/ID; saturating.
- `stall_cnt`  out  32  count of load-use stall cycles; saturating.
- `flush_cnt`  out  32  count of redirect cycles; saturating.

## Operation
- PC register update, evaluated at each rising edge in priority order:
  1. `rst`=0: PC ← `RESET_PC`.
  2. `load_use_stall_flag`=1: PC holds.
  3. `jump_en`=1: PC ← {`jump_target`[31:2], 2'b00}.
  4. Otherwise: PC ← PC+4.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0); no carry out.
- `imem_addr` = `pc_o` = PC; `pc4_o` = PC+4; `inst_o` = `imem_rdata`. All three are combinational from PC.
- `jump_stall_flag` = `jump_en` & ~`load_use_stall_flag` & `rst`. It is combinational, so IF/ID discards the wrong-path instruction on the same edge the PC redirects.
- Simultaneous stall and jump: the stall wins and the jump is ignored. This matches IF/ID, where stall has priority over flush. The hazard unit guarantees the two are exclusive; the bench flags any overlap as a warning.
- `misalign_err`:
  - Set on any edge where a redirect is taken (priority 3) with `jump_target[1:0]`≠0.
  - Cleared only by reset.
  - The target low bits are forced to zero regardless.
- Counters increment by 1 on an edge with `rst`=1 and hold at 32'hFFFF_FFFF:
  - `fetch_cnt`: on priority-4 edges.
  - `stall_cnt`: on priority-2 edges.
  - `flush_cnt`: on priority-3 edges.
- Exactly one counter, or none if saturated, advances per non-reset edge.

## Timing
- Reset values, visible after the first edge with `rst`=0:
  - `pc_o` = `RESET_PC`; `pc4_o` = `RESET_PC`+4.
  - `misalign_err` = 0.
  - All counters = 0.
  - `jump_stall_flag` = 0 while `rst`=0.
- Reset asserted mid-stream overrides stall and jump on that edge. The counters clear even if saturated.
- Latency:
  - Sequential fetch: PC advances 1 per cycle.
  - Redirect: `jump_target` becomes `pc_o` one edge after `jump_en` is sampled.
  - Stall: `pc_o` is unchanged for exactly as many edges as `load_use_stall_flag` is high.
- No combinational path from `imem_rdata` to any control output.

## Test plan
- Reset, then 4 free-running cycles with `RESET_PC`=0 → `pc_o` = 0,4,8,C; `pc4_o` = 4,8,C,10; `fetch_cnt`=4; `jump_stall_flag`=0 throughout.
- At `pc_o`=8, stall for 2 cycles → `pc_o` stays 8 for 2 edges, then 0xC; `stall_cnt`=2; `fetch_cnt` unaffected during the stall.
- At `pc_o`=0x10, `jump_en`=1 with target 0x100 → `jump_stall_flag`=1 that cycle; next `pc_o`=0x100, `pc4_o`=0x104; `flush_cnt`=1.
- Jump to 0x203 → next `pc_o`=0x200; `misalign_err`=1, and it stays 1 through later normal jumps until reset.
- Stall and jump asserted together with target 0x40 at `pc_o`=0x20 → `pc_o` holds 0x20; `jump_stall_flag`=0; only `stall_cnt` increments.
- Cases:
  - Jump to 0xFFFF_FFFC then run free → `pc_o` wraps to 0.
  - Force `fetch_cnt` near 0xFFFF_FFFF → it saturates.
  - `rst`=0 during an active stall → `pc_o`=`RESET_PC` and all counters 0 on the next edge.
